mem_stage_requester: RTL and testbench

//  Initiator side of the Y86-64 data-memory interface. Turns the memory-stage

---
 rtl/mem_stage_requester.sv | 121 ++++++++++++
 tb/tb_mem_stage_requester.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_requester.sv
// Y86-64 memory-stage requester: decodes M-stage fields into a registered
// req/ack access to a multi-cycle data memory. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage_requester #(
  parameter logic [63:0] ADDR_LIMIT = 64'd512,
  parameter int          TIMEOUT    = 16,
  parameter int          CNT_W      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic [63:0] valM,
  output logic        m_stall,
  output logic        m_done,
  output logic        dmem_error
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_wr, memop, illegal;
  logic [63:0]        req_addr, req_wdata;

  always_comb begin
    is_wr     = 1'b0;
    memop     = 1'b1;
    req_addr  = valE;
    req_wdata = valA;
    case (icode)
      4'h4, 4'hA: is_wr = 1'b1;
      4'h5:       ;
      4'h8: begin
        is_wr     = 1'b1;
        req_wdata = valP;
      end
      4'h9, 4'hB: req_addr = valA;
      default:    memop = 1'b0;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    illegal = (req_addr >= ADDR_LIMIT) || (req_addr[2:0] != 3'b000);
`else
    illegal = (req_addr >= ADDR_LIMIT);
`endif
  end

  assign m_stall = m_valid & memop & ((state == IDLE) | (state == REQ));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      valM       <= '0;
      m_done     <= 1'b0;
      dmem_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m_done <= 1'b0;
          if (m_valid && memop) begin
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            mem_we    <= is_wr;
            cnt       <= '0;
            // Illegal addresses never reach the memory bus.
            if (illegal) begin
              state      <= ERR;
              dmem_error <= 1'b1;
            end else begin
              state   <= REQ;
              mem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          // Ack is tested first so it wins over a coincident timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_err) begin
              state      <= ERR;
              dmem_error <= 1'b1;
            end else begin
              if (!mem_we) valM <= mem_rdata;
              m_done <= 1'b1;
              state  <= DONE;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req    <= 1'b0;
            state      <= ERR;
            dmem_error <= 1'b1;
          end
        end
        DONE: begin
          m_done <= 1'b0;
          state  <= IDLE;
        end
        ERR: begin
          mem_req <= 1'b0;
          m_done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_requester.sv
// Directed bench for mem_stage_requester; expected values are hand-computed.
module tb_mem_stage_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_err;
  logic [63:0] valM;
  logic        m_stall, m_done, dmem_error;

  int errors = 0;
  int checks = 0;

  mem_stage_requester dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .valM(valM), .m_stall(m_stall), .m_done(m_done), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; m_valid = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    icode = 4'h1; valE = '0; valA = '0; valP = '0; mem_rdata = '0;
    do_reset();
    chk("rst_req", mem_req, 0);
    chk("rst_done", m_done, 0);
    chk("rst_err", dmem_error, 0);
    chk("rst_valM", valM, 0);
    chk("rst_stall", m_stall, 0);

    // 1: mrmovq, ack on 2nd REQ cycle
    m_valid = 1; icode = 4'h5; valE = 64'h40; valA = 64'h999;
    #1 chk("t1_stall_idle", m_stall, 1);
    tick();
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 64'h40);
    chk("t1_we", mem_we, 0);
    chk("t1_stall_req1", m_stall, 1);
    tick();
    chk("t1_req2", mem_req, 1);
    mem_ack = 1; mem_rdata = 64'hDEAD;
    #1 chk("t1_stall_req2", m_stall, 1);
    tick();
    mem_ack = 0; mem_rdata = 64'hBEEF;
    chk("t1_done", m_done, 1);
    chk("t1_valM", valM, 64'hDEAD);
    chk("t1_req_low", mem_req, 0);
    chk("t1_stall_done", m_stall, 0);
    m_valid = 0;
    tick();
    chk("t1_done_pulse", m_done, 0);

    // 2: call writes valP, then ret reads via valA
    m_valid = 1; icode = 4'h8; valE = 64'h1F8; valP = 64'h123; valA = 64'h999;
    tick();
    chk("t2_we", mem_we, 1);
    chk("t2_addr", mem_addr, 64'h1F8);
    chk("t2_wdata", mem_wdata, 64'h123);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("t2_done", m_done, 1);
    chk("t2_valM_kept", valM, 64'hDEAD);
    icode = 4'h9; valA = 64'h1F8; valE = 64'h200;
    tick();
    chk("t2_ret_stall", m_stall, 1);
    tick();
    chk("t2_ret_addr", mem_addr, 64'h1F8);
    chk("t2_ret_we", mem_we, 0);
    chk("t2_ret_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 64'h55;
    tick();
    mem_ack = 0; m_valid = 0;
    chk("t2_ret_valM", valM, 64'h55);

    // 5: reset on 2nd REQ cycle, late ack ignored, opq no stall
    tick();
    m_valid = 1; icode = 4'h5; valE = 64'h10;
    tick();
    tick();
    chk("t5_req2", mem_req, 1);
    reset = 1;
    tick();
    chk("t5_req", mem_req, 0);
    chk("t5_valM", valM, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_err", dmem_error, 0);
    reset = 0; m_valid = 0; mem_ack = 1; mem_rdata = 64'h66;
    tick();
    mem_ack = 0;
    chk("t5_late_done", m_done, 0);
    chk("t5_late_valM", valM, 0);
    m_valid = 1; icode = 4'h6;
    #1 chk("t5_opq_stall", m_stall, 0);
    tick();
    chk("t5_opq_req", mem_req, 0);

    // 3: address at ADDR_LIMIT
    icode = 4'h4; valE = 64'h200; valA = 64'h7;
    #1 chk("t3_stall_idle", m_stall, 1);
    tick();
    chk("t3_req", mem_req, 0);
    chk("t3_err", dmem_error, 1);
    chk("t3_stall", m_stall, 0);
    tick();
    chk("t3_req_later", mem_req, 0);
    chk("t3_err_sticky", dmem_error, 1);

    // high-bit address is illegal under unsigned compare
    do_reset();
    m_valid = 1; icode = 4'h5; valE = 64'h8000_0000_0000_0000;
    tick();
    chk("t3b_req", mem_req, 0);
    chk("t3b_err", dmem_error, 1);

    // 4: popq with no ack times out after 16 REQ cycles
    do_reset();
    m_valid = 1; icode = 4'hB; valA = 64'h100;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t4_req_hold", mem_req, 1);
      chk("t4_no_err", dmem_error, 0);
    end
    tick();
    chk("t4_timeout_err", dmem_error, 1);
    chk("t4_timeout_req", mem_req, 0);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("t4_err_sticky", dmem_error, 1);
    chk("t4_ack_ignored", m_done, 0);

    // ack coinciding with last timeout cycle wins
    do_reset();
    m_valid = 1; icode = 4'hB; valA = 64'h100;
    tick();
    for (int i = 0; i < 15; i++) tick();
    mem_ack = 1; mem_rdata = 64'h77;
    tick();
    mem_ack = 0; m_valid = 0;
    chk("t4_race_done", m_done, 1);
    chk("t4_race_err", dmem_error, 0);
    chk("t4_race_valM", valM, 64'h77);

    // bus error on ack
    do_reset();
    m_valid = 1; icode = 4'h5; valE = 64'h80;
    tick();
    mem_ack = 1; mem_err = 1; mem_rdata = 64'h88;
    tick();
    mem_ack = 0; mem_err = 0;
    chk("t4_buserr", dmem_error, 1);
    chk("t4_buserr_done", m_done, 0);
    chk("t4_buserr_valM", valM, 0);
    chk("t4_buserr_stall", m_stall, 0);

    // 6: misaligned access
    do_reset();
    m_valid = 1; icode = 4'h5; valE = 64'h44;
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    chk("t6_req", mem_req, 0);
    chk("t6_err", dmem_error, 1);
`else
    chk("t6_req", mem_req, 1);
    chk("t6_addr", mem_addr, 64'h44);
    mem_ack = 1; mem_rdata = 64'hAB;
    tick();
    mem_ack = 0;
    chk("t6_done", m_done, 1);
    chk("t6_valM", valM, 64'hAB);
    chk("t6_err", dmem_error, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
